// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : shared fetch/decode types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [INSTR_W-1:0] npc;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/pfb_storage.sv
// ============================================================================
// pfb_storage : DEPTH x fetch_entry_t register array, sync write / async read
// Rev 1.0
// ============================================================================
`default_nettype none

module pfb_storage
   import pipeline_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  fetch_entry_t  wdata,
   input  logic [AW-1:0] raddr,
   output fetch_entry_t  rdata
);

   fetch_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/if_prefetch_buffer.sv
// ============================================================================
// if_prefetch_buffer : fetch->decode prefetch FIFO with branch flush.
// Optional macro PFB_BYPASS_EN: zero-latency pass-through when empty.
// Rev 1.0
// ============================================================================
`default_nettype none

module if_prefetch_buffer
   import pipeline_pkg::*;
#(
   parameter int                 DEPTH    = 4,
   parameter logic [INSTR_W-1:0] NOP_WORD = NOP_INSTR
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [31:0]              in_npc,
   input  logic                     flush,
   input  logic                     stall,
   output logic                     out_valid,
   output logic [31:0]              IF_ID_instr,
   output logic [31:0]              IF_ID_npc,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic         head_valid;
   logic         bypass;
   logic         push;
   logic         pop;
   logic         we;
   fetch_entry_t wdata;
   fetch_entry_t head;

   assign in_ready   = (count != FULL_COUNT);
   assign head_valid = (count != '0);

`ifdef PFB_BYPASS_EN
   // Empty buffer hands the fetched entry straight to decode; it is never stored.
   assign bypass = (count == '0) & in_valid & ~stall & ~flush;
`else
   assign bypass = 1'b0;
`endif

   assign push  = in_valid & in_ready & ~bypass;
   assign pop   = head_valid & ~stall;
   assign we    = push & ~flush & ~rst;
   assign wdata = '{instr: in_instr, npc: in_npc};

   pfb_storage #(
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_storage (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (head)
   );

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign out_valid   = head_valid | bypass;
   assign IF_ID_instr = head_valid ? head.instr : (bypass ? in_instr : NOP_WORD);
   assign IF_ID_npc   = head_valid ? head.npc   : (bypass ? in_npc   : 32'h0);
   assign occupancy   = count;

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch_buffer.sv
// ============================================================================
// tb_if_prefetch_buffer : directed scoreboard bench for if_prefetch_buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_prefetch_buffer;
   import pipeline_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_npc;
   logic        flush;
   logic        stall;
   logic        out_valid;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_npc;
   logic [2:0]  occupancy;

   fetch_entry_t exp_q[$];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   if_prefetch_buffer #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_npc      (in_npc),
      .flush       (flush),
      .stall       (stall),
      .out_valid   (out_valid),
      .IF_ID_instr (IF_ID_instr),
      .IF_ID_npc   (IF_ID_npc),
      .occupancy   (occupancy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: drive, check at negedge against the queue model, update model.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] npc,
                        input logic st, input logic fl, input string tag);
      logic         byp;
      logic         ev;
      logic         do_push;
      logic         do_pop;
      fetch_entry_t e;
      in_valid = v;
      in_instr = ins;
      in_npc   = npc;
      stall    = st;
      flush    = fl;
      @(negedge clk);
      byp = 1'b0;
`ifdef PFB_BYPASS_EN
      byp = (exp_q.size() == 0) && v && !st && !fl;
`endif
      ev = (exp_q.size() != 0) || byp;
      if (exp_q.size() != 0)  e = exp_q[0];
      else if (byp)           e = '{instr: ins, npc: npc};
      else                    e = '{instr: NOP_INSTR, npc: 32'h0};
      chk({tag, ".occupancy"}, 32'(occupancy), 32'(exp_q.size()));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(exp_q.size() != DEPTH));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
      chk({tag, ".instr"},     IF_ID_instr,    e.instr);
      chk({tag, ".npc"},       IF_ID_npc,      e.npc);
      if (fl) begin
         exp_q.delete();
      end else if (!byp) begin
         do_push = v && (exp_q.size() != DEPTH);
         do_pop  = (exp_q.size() != 0) && !st;
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back('{instr: ins, npc: npc});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_npc = '0; stall = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "reset_idle");

      // Fill under stall, offer a fifth word while full.
      cycle(1'b1, 32'h8C02_0000, 32'h4,  1'b1, 1'b0, "fill0");
      cycle(1'b1, 32'h8C03_0004, 32'h8,  1'b1, 1'b0, "fill1");
      cycle(1'b1, 32'h0043_2020, 32'hC,  1'b1, 1'b0, "fill2");
      cycle(1'b1, 32'hAC04_0008, 32'h10, 1'b1, 1'b0, "fill3");
      cycle(1'b1, 32'hDEAD_0005, 32'h14, 1'b1, 1'b0, "full_hold");
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, $sformatf("drain%0d", i));

      // Prime two entries, then streaming push+pop across pointer wrap.
      cycle(1'b1, 32'h1000_0000, 32'h100, 1'b1, 1'b0, "prime0");
      cycle(1'b1, 32'h1000_0001, 32'h104, 1'b1, 1'b0, "prime1");
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 32'h2000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0,
               $sformatf("wrap%0d", i));
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, $sformatf("wdrain%0d", i));

      // Flush with a same-cycle push and pop request.
      cycle(1'b1, 32'h3000_0000, 32'h300, 1'b1, 1'b0, "pf0");
      cycle(1'b1, 32'h3000_0001, 32'h304, 1'b1, 1'b0, "pf1");
      cycle(1'b1, 32'h3000_0002, 32'h308, 1'b1, 1'b0, "pf2");
      cycle(1'b1, 32'hDEAD_BEEF, 32'h30C, 1'b0, 1'b1, "flush");
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "post_flush0");
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "post_flush1");

      // Single word into an empty buffer: same cycle with bypass, next cycle without.
      cycle(1'b1, 32'h0022_1820, 32'h104, 1'b0, 1'b0, "bypass");
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "bypass_next");
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "bypass_idle");

      // Reset mid-operation with an in-flight push.
      cycle(1'b1, 32'h4000_0000, 32'h400, 1'b1, 1'b0, "pr0");
      cycle(1'b1, 32'h4000_0001, 32'h404, 1'b1, 1'b0, "pr1");
      rst = 1'b1; in_valid = 1'b1; in_instr = 32'h4000_0002; in_npc = 32'h408; stall = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "post_rst0");
      cycle(1'b1, 32'h5000_0000, 32'h500, 1'b0, 1'b0, "post_rst_push");
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "post_rst1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
